// File: rtl/pmem_responder_pkg.sv
// ---------------------------------------------------------------------------
// pmem_responder_pkg
// Shared definitions for the pmem_responder slice: responder FSM state enum,
// data/mask/counter widths, default parameter values and the address decode
// helpers used to turn a byte address into a storage word index.
// No ports (package).
// ---------------------------------------------------------------------------
package pmem_responder_pkg;

  // Storage word is 64 bits wide, with one write-enable bit per byte lane.
  localparam int WORD_W = 64;
  localparam int MASK_W = WORD_W / 8;

  // Wait counter holds LATENCY, which is limited to 0..15.
  localparam int CNT_W = 4;

  // Default parameter values for the responder and its storage.
  localparam logic [63:0] DEFAULT_MEM_BASE    = 64'h0000_0000_8000_0000;
  localparam int          DEFAULT_DEPTH_WORDS = 1024;
  localparam int          DEFAULT_LATENCY     = 2;

  // Responder transaction state.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // Word offset from the base. The subtraction is done in the full 64 bits,
  // so an address below the base wraps to a huge offset and then fails the
  // range check instead of aliasing onto the top of the array.
  function automatic logic [63:0] word_offset(input logic [63:0] addr,
                                              input logic [63:0] base);
    logic [63:0] byte_off;
    byte_off = addr - base;
    return byte_off >> 3;
  endfunction

  // A word offset is valid only if it falls inside the storage array.
  function automatic logic word_in_range(input logic [63:0] word_off,
                                         input logic [63:0] depth);
    return word_off < depth;
  endfunction

endpackage

// File: rtl/pmem_responder_if.sv
// ---------------------------------------------------------------------------
// pmem_responder_if
// Request/response bundle between an initiator and the pmem_responder.
//   req_valid/req_ready : request handshake (initiator -> responder)
//   req_write           : 1 = write, 0 = read
//   req_addr            : byte address, bits [2:0] ignored
//   req_wdata/req_wmask : write data and per-byte write enables
//   rsp_valid/rsp_ready : response handshake (responder -> initiator)
//   rsp_rdata/rsp_err   : read data (0 for writes/errors), range error flag
// Modports: master = initiator side, slave = responder side.
// ---------------------------------------------------------------------------
interface pmem_responder_if;
  import pmem_responder_pkg::*;

  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [63:0]       req_addr;
  logic [WORD_W-1:0] req_wdata;
  logic [MASK_W-1:0] req_wmask;

  logic              rsp_valid;
  logic              rsp_ready;
  logic [WORD_W-1:0] rsp_rdata;
  logic              rsp_err;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, req_wmask, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, req_wmask, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );

endinterface

// File: rtl/pmem_responder_sram.sv
// ---------------------------------------------------------------------------
// pmem_sram
// DEPTH_WORDS x 64-bit storage array with a single synchronous port.
//   clk   : clock
//   en    : port enable for this cycle
//   we    : 1 = byte-masked write, 0 = read
//   addr  : word index
//   wdata : write data, byte lane i = wdata[8i+7:8i]
//   wmask : per-byte write enable
//   rdata : registered read data, updated only on an enabled read
// No reset: contents survive a responder reset.
// ---------------------------------------------------------------------------
module pmem_sram
  import pmem_responder_pkg::*;
#(
  parameter  int DEPTH_WORDS = DEFAULT_DEPTH_WORDS,
  localparam int AW          = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [AW-1:0]     addr,
  input  logic [WORD_W-1:0] wdata,
  input  logic [MASK_W-1:0] wmask,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem [DEPTH_WORDS];

  // Single port: a write updates only the enabled byte lanes; a read loads
  // the output register, which then holds its value until the next read.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int b = 0; b < MASK_W; b++) begin
          if (wmask[b]) begin
            mem[addr][8*b +: 8] <= wdata[8*b +: 8];
          end
        end
      end else begin
        rdata <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/pmem_responder.sv
// ---------------------------------------------------------------------------
// pmem_responder
// Single-outstanding memory responder with fixed access latency. A request
// is latched in IDLE, waits LATENCY cycles, performs one storage access on
// the cycle it enters RESP, then holds the response until the initiator
// takes it.
//   clk   : clock, all state updates on the rising edge
//   rst_n : asynchronous active-low reset
//   bus   : pmem_responder_if.slave request/response bundle
// Parameters: MEM_BASE (byte address of word 0), DEPTH_WORDS (power of two),
// LATENCY (0..15 wait cycles).
// ---------------------------------------------------------------------------
module pmem_responder
  import pmem_responder_pkg::*;
#(
  parameter logic [63:0] MEM_BASE    = DEFAULT_MEM_BASE,
  parameter int          DEPTH_WORDS = DEFAULT_DEPTH_WORDS,
  parameter int          LATENCY     = DEFAULT_LATENCY
) (
  input logic             clk,
  input logic             rst_n,
  pmem_responder_if.slave bus
);

  localparam int              AW      = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [CNT_W-1:0] LAT_CNT = CNT_W'(LATENCY);

  state_t            state;
  state_t            next_state;
  logic [CNT_W-1:0]  cnt;
  logic              ready_armed;

  logic              lat_write;
  logic [63:0]       lat_addr;
  logic [WORD_W-1:0] lat_wdata;
  logic [MASK_W-1:0] lat_wmask;

  logic              rsp_err_q;
  logic              rsp_read_q;

  logic              accept;
  logic              access;
  logic              acc_write;
  logic [63:0]       acc_addr;
  logic [WORD_W-1:0] acc_wdata;
  logic [MASK_W-1:0] acc_wmask;
  logic [63:0]       acc_word;
  logic              acc_in_range;
  logic [WORD_W-1:0] sram_rdata;

  // State register. Reset drops any transaction in flight; since the
  // storage is only touched on entry to RESP, aborting in WAIT leaves
  // memory untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state and handshake outputs. req_ready is additionally gated by
  // ready_armed so it stays low while reset is held and for the first edge
  // after release. With LATENCY == 0 the access happens on the accepting
  // edge itself, straight from the live request fields.
  always_comb begin
    next_state    = state;
    accept        = 1'b0;
    access        = 1'b0;
    bus.req_ready = 1'b0;
    bus.rsp_valid = 1'b0;
    unique case (state)
      ST_IDLE: begin
        bus.req_ready = ready_armed;
        if (ready_armed && bus.req_valid) begin
          accept = 1'b1;
          if (LATENCY == 0) begin
            next_state = ST_RESP;
            access     = 1'b1;
          end else begin
            next_state = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (cnt == CNT_W'(1)) begin
          next_state = ST_RESP;
          access     = 1'b1;
        end
      end
      ST_RESP: begin
        bus.rsp_valid = 1'b1;
        if (bus.rsp_ready) begin
          next_state = ST_IDLE;
        end
      end
      default: begin
        next_state = ST_IDLE;
      end
    endcase
  end

  // Request capture, wait counter and response flags. The request fields
  // are frozen at acceptance so the initiator may change its inputs freely
  // while the transaction is in progress. The response flags are captured
  // on the access edge and then held for the whole RESP phase.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt         <= '0;
      ready_armed <= 1'b0;
      lat_write   <= 1'b0;
      lat_addr    <= '0;
      lat_wdata   <= '0;
      lat_wmask   <= '0;
      rsp_err_q   <= 1'b0;
      rsp_read_q  <= 1'b0;
    end else begin
      ready_armed <= 1'b1;
      if (accept) begin
        lat_write <= bus.req_write;
        lat_addr  <= bus.req_addr;
        lat_wdata <= bus.req_wdata;
        lat_wmask <= bus.req_wmask;
        cnt       <= LAT_CNT;
      end else if (state == ST_WAIT) begin
        cnt <= cnt - CNT_W'(1);
      end
      if (access) begin
        rsp_err_q  <= !acc_in_range;
        rsp_read_q <= !acc_write;
      end
    end
  end

  // Access fields: live inputs when the access coincides with acceptance
  // (zero latency), otherwise the latched copy.
  assign acc_write    = (state == ST_IDLE) ? bus.req_write : lat_write;
  assign acc_addr     = (state == ST_IDLE) ? bus.req_addr  : lat_addr;
  assign acc_wdata    = (state == ST_IDLE) ? bus.req_wdata : lat_wdata;
  assign acc_wmask    = (state == ST_IDLE) ? bus.req_wmask : lat_wmask;
  assign acc_word     = word_offset(acc_addr, MEM_BASE);
  assign acc_in_range = word_in_range(acc_word, 64'(DEPTH_WORDS));

  // Response data is forced to zero outside RESP and for writes and range
  // errors, so the stale SRAM read register never leaks out.
  assign bus.rsp_err   = (state == ST_RESP) && rsp_err_q;
  assign bus.rsp_rdata = ((state == ST_RESP) && rsp_read_q && !rsp_err_q) ?
                         sram_rdata : '0;

  // Out-of-range requests never enable the array, which suppresses the
  // write and keeps the index slice below meaningful.
  pmem_sram #(
    .DEPTH_WORDS (DEPTH_WORDS)
  ) u_sram (
    .clk   (clk),
    .en    (access && acc_in_range),
    .we    (acc_write),
    .addr  (acc_word[AW-1:0]),
    .wdata (acc_wdata),
    .wmask (acc_wmask),
    .rdata (sram_rdata)
  );

endmodule
